// File: rtl/sha_round_controller_if.sv
// Bundle of job-control, counter and datapath strobe signals around the SHA-256 round controller.
// master = controller side, slave = job FSM / hash core / counter side.
interface sha_round_controller_if;
  logic       start;
  logic       abort;
  logic [6:0] cnt_value;
  logic       cnt_complete;
  logic       cnt_enable;
  logic       cnt_restart;
  logic       load_iv;
  logic       load_chain;
  logic       round_en;
  logic       w_sel;
  logic       accum_en;
  logic [1:0] pass_idx;
  logic       busy;
  logic       done;
  logic       sync_err;

  modport master (
    input  start, abort, cnt_value, cnt_complete,
    output cnt_enable, cnt_restart, load_iv, load_chain, round_en, w_sel,
           accum_en, pass_idx, busy, done, sync_err
  );

  modport slave (
    output start, abort, cnt_value, cnt_complete,
    input  cnt_enable, cnt_restart, load_iv, load_chain, round_en, w_sel,
           accum_en, pass_idx, busy, done, sync_err
  );
endinterface

// File: rtl/sha_round_controller.sv
// Sequences SHA-256 compression passes (INIT, 64 rounds, ACCUM) and drives the 7-bit round counter.
// Strobes are decoded from the registered state; abort and counter desync override them in the same cycle.
module sha_round_controller #(
  parameter int NUM_PASSES  = 3,
  parameter int STD_IV_PASS = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  sha_round_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST_PASS       = 2'(NUM_PASSES - 1);
  localparam logic [1:0] IV_PASS         = 2'(STD_IV_PASS);
  localparam logic [6:0] LAST_ROUND      = 7'd63;
  localparam logic [6:0] FIRST_EXP_ROUND = 7'd16;

  state_t     state_q;
  logic [1:0] pass_q;
  logic       sync_err_q;

  logic desync;
  logic kill;

  // Counter must be mid-run throughout ROUND and exactly complete in ACCUM.
  assign desync = ((state_q == S_ROUND) &&  bus.cnt_complete) ||
                  ((state_q == S_ACCUM) && !bus.cnt_complete);
  assign kill   = bus.abort | desync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      pass_q     <= 2'd0;
      sync_err_q <= 1'b0;
    end else if (bus.abort) begin
      state_q <= S_IDLE;
      pass_q  <= 2'd0;
    end else if (desync) begin
      state_q    <= S_IDLE;
      sync_err_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_INIT;
            pass_q     <= 2'd0;
            sync_err_q <= 1'b0;
          end
        end
        S_INIT:  state_q <= S_ROUND;
        S_ROUND: begin
          if (bus.cnt_value == LAST_ROUND) begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (pass_q == LAST_PASS) begin
            state_q <= S_DONE;
          end else begin
            pass_q  <= pass_q + 2'd1;
            state_q <= S_INIT;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic ctr_en;
  logic ctr_rst;
  logic ld_iv;
  logic ld_chain;
  logic rnd_en;
  logic wsel;
  logic acc_en;
  logic done_p;

  always_comb begin
    ctr_en   = 1'b0;
    ctr_rst  = 1'b0;
    ld_iv    = 1'b0;
    ld_chain = 1'b0;
    rnd_en   = 1'b0;
    wsel     = 1'b0;
    acc_en   = 1'b0;
    done_p   = 1'b0;
    if (kill) begin
      ctr_rst = 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          ctr_rst  = 1'b1;
          ld_iv    = (pass_q == 2'd0) || (pass_q == IV_PASS);
          ld_chain = !((pass_q == 2'd0) || (pass_q == IV_PASS));
        end
        S_ROUND: begin
          rnd_en = 1'b1;
          ctr_en = 1'b1;
          wsel   = (bus.cnt_value >= FIRST_EXP_ROUND);
        end
        S_ACCUM: acc_en = 1'b1;
        S_DONE:  done_p = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cnt_enable  = ctr_en;
  assign bus.cnt_restart = ctr_rst;
  assign bus.load_iv     = ld_iv;
  assign bus.load_chain  = ld_chain;
  assign bus.round_en    = rnd_en;
  assign bus.w_sel       = wsel;
  assign bus.accum_en    = acc_en;
  assign bus.done        = done_p;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.pass_idx    = pass_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_sha_round_controller.sv
// Directed/randomized bench for sha_round_controller with a 0..64 round counter and a job-cycle reference model.
module tb_sha_round_controller;

  localparam int PASS_LEN = 66;
  localparam int JOB_LEN  = 3 * PASS_LEN + 1;

  logic clk;
  logic n_rst;
  logic force_hi;
  logic force_lo;
  logic [6:0] cnt_q;

  sha_round_controller_if bus ();

  sha_round_controller #(.NUM_PASSES(3), .STD_IV_PASS(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round counter, RESTART_VAL=0, MAX_VAL=64
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)               cnt_q <= 7'd0;
    else if (bus.cnt_restart) cnt_q <= 7'd0;
    else if (bus.cnt_enable)  cnt_q <= (cnt_q == 7'd64) ? 7'd0 : cnt_q + 7'd1;
  end

  assign bus.cnt_value    = cnt_q;
  assign bus.cnt_complete = force_lo ? 1'b0 : (force_hi ? 1'b1 : (cnt_q == 7'd64));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: k = cycle number within the current job (0 = idle)
  int       k;
  int       m_pass;
  logic     m_err;
  int       m_idle_cnt;
  int       rounds_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  function automatic logic [11:0] outs();
    return {bus.cnt_enable, bus.cnt_restart, bus.load_iv, bus.load_chain, bus.round_en,
            bus.w_sel, bus.accum_en, bus.busy, bus.done, bus.sync_err, bus.pass_idx};
  endfunction

  // Called at posedge+1; applies inputs for this cycle, checks outputs, advances the model.
  task automatic run_cycle(input logic st, input logic ab, input logic f_hi, input logic f_lo);
    int ph, p, r, t, exp_cnt;
    logic cc_in, desync, kill;
    logic e_en, e_rst, e_iv, e_ch, e_rnd, e_ws, e_acc, e_busy, e_done;
    int e_pass;
    bus.start = st;
    bus.abort = ab;
    force_hi  = f_hi;
    force_lo  = f_lo;
    #1;
    p = 0; r = 0; t = 0;
    if (k == 0)             ph = 0;
    else if (k == JOB_LEN)  ph = 4;
    else begin
      p  = (k - 1) / PASS_LEN;
      r  = (k - 1) % PASS_LEN;
      ph = (r == 0) ? 1 : ((r == PASS_LEN - 1) ? 3 : 2);
      t  = r - 1;
    end
    case (ph)
      0:       exp_cnt = m_idle_cnt;
      1:       exp_cnt = (p == 0) ? m_idle_cnt : 64;
      2:       exp_cnt = t;
      default: exp_cnt = 64;
    endcase
    cc_in  = f_lo ? 1'b0 : (f_hi ? 1'b1 : (exp_cnt == 64));
    desync = ((ph == 2) && cc_in) || ((ph == 3) && !cc_in);
    kill   = ab || desync;
    {e_en, e_rst, e_iv, e_ch, e_rnd, e_ws, e_acc, e_done} = '0;
    e_busy = (ph != 0);
    if (kill) e_rst = 1'b1;
    else begin
      case (ph)
        1: begin e_rst = 1'b1; e_iv = (p == 0 || p == 2); e_ch = !(p == 0 || p == 2); end
        2: begin e_rnd = 1'b1; e_en = 1'b1; e_ws = (t >= 16); end
        3: e_acc = 1'b1;
        4: e_done = 1'b1;
        default: ;
      endcase
    end
    e_pass = (ph == 0) ? m_pass : ((ph == 4) ? 2 : p);
    chk($sformatf("outs k=%0d", k), 32'(outs()),
        32'({e_en, e_rst, e_iv, e_ch, e_rnd, e_ws, e_acc, e_busy, e_done, m_err, 2'(e_pass)}));
    chk($sformatf("cnt_value k=%0d", k), 32'(cnt_q), 32'(exp_cnt));
    if (bus.round_en) rounds_seen++;
    if (ab) begin
      k = 0; m_pass = 0; m_idle_cnt = 0;
    end else if (desync) begin
      k = 0; m_err = 1'b1; m_pass = p; m_idle_cnt = 0;
    end else if (k == 0) begin
      if (st) begin k = 1; m_err = 1'b0; m_pass = 0; end
    end else if (ph == 4) begin
      k = 0; m_pass = 2; m_idle_cnt = 64;
    end else begin
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    force_hi  = 1'b0;
    force_lo  = 1'b0;
    #1;
    chk("reset outs", 32'(outs()), 32'd0);
    chk("reset cnt", 32'(cnt_q), 32'd0);
    @(posedge clk);
    #1;
    chk("reset held outs", 32'(outs()), 32'd0);
    n_rst = 1'b1;
    k = 0; m_pass = 0; m_err = 1'b0; m_idle_cnt = 0;
  endtask

  task automatic run_job(input string name, input int abort_at, input int hi_at, input int lo_at,
                         input int rst_at, input int sa, input int sb, input bit full);
    int guard;
    rounds_seen = 0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (k != 0 && guard < 400) begin
      if (k == rst_at) begin
        do_reset();
        break;
      end
      run_cycle(k == sa || k == sb, k == abort_at, k == hi_at, k == lo_at);
      guard++;
    end
    chk({name, " terminates"}, 32'(guard < 400), 32'd1);
    if (full) chk({name, " round_en count"}, 32'(rounds_seen), 32'd192);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    $display("job %s: rounds=%0d sync_err=%0b pass_idx=%0d", name, rounds_seen,
             bus.sync_err, bus.pass_idx);
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) run_cycle(1'b0, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    force_hi = 1'b0;
    force_lo = 1'b0;
    k = 0; m_pass = 0; m_err = 1'b0; m_idle_cnt = 0; rounds_seen = 0;
    @(posedge clk);
    #1;
    do_reset();
    idle_gap();

    run_job("full_repulse", 0, 0, 0, 0, 5, JOB_LEN, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle_gap();
    run_job("abort100", 100, 0, 0, 0, 0, 0, 1'b0);
    idle_gap();
    run_job("full_rand", 0, 0, 0, 0, $urandom_range(2, JOB_LEN - 1), $urandom_range(2, JOB_LEN), 1'b1);
    idle_gap();
    run_job("desync_round", 0, 30, 0, 0, 0, 0, 1'b0);
    idle_gap();
    run_job("desync_accum", 0, 0, PASS_LEN, 0, 0, 0, 1'b0);
    idle_gap();
    run_job("abort_rand", $urandom_range(1, JOB_LEN), 0, 0, 0, 0, 0, 1'b0);
    idle_gap();
    run_job("reset70", 0, 0, 0, 70, 0, 0, 1'b0);
    idle_gap();
    run_job("full_after", 0, 0, 0, 0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
